// File: rtl/hood_pkg.sv
// Shared types and defaults for the range-hood power controller
// and the exhaust block it drives.
package hood_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_CLEAN = 2'd2
  } hood_state_t;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEVEL1 = 2'd1,
    MODE_LEVEL2 = 2'd2,
    MODE_LEVEL3 = 2'd3
  } hood_mode_t;

  localparam int unsigned LONG_PRESS_S_DEF  = 3;
  localparam int unsigned GESTURE_WIN_S_DEF = 5;
  localparam int unsigned CLEAN_S_DEF       = 180;
  localparam int unsigned REMIND_S_DEF      = 36000;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tick_down_counter.sv
// 8-bit loadable seconds down-counter; stops at zero.
// Priority: clear, then load, then tick.
module tick_down_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       clear,
  output logic [7:0] count,
  output logic       zero
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = 8'd0;
    else if (load)
      cnt_d = load_val;
    else if (tick && cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == 8'd0);

endmodule

// File: rtl/hood_power_ctrl.sv
// Range-hood power/maintenance controller: on/off from keys and
// gestures, timed self-clean, run-time reminder.
module hood_power_ctrl
  import hood_pkg::*;
#(
  parameter int unsigned LONG_PRESS_S  = LONG_PRESS_S_DEF,
  parameter int unsigned GESTURE_WIN_S = GESTURE_WIN_S_DEF,
  parameter int unsigned CLEAN_S       = CLEAN_S_DEF,
  parameter int unsigned REMIND_S      = REMIND_S_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sec_tick,
  input  logic        power_key,
  input  logic        clean_key,
  input  logic        gesture_l,
  input  logic        gesture_r,
  input  logic        hood_busy,
  input  logic        hood_cd_active,
  output logic        is_on,
  output logic        clean_active,
  output logic [7:0]  clean_cd,
  output logic [15:0] work_sec,
  output logic        reminder,
  output logic [1:0]  state
);

  localparam logic [7:0]  HOLD_LAST = 8'(LONG_PRESS_S - 1);
  localparam logic [7:0]  WIN_LD    = 8'(GESTURE_WIN_S);
  localparam logic [7:0]  CLEAN_LD  = 8'(CLEAN_S);
  localparam logic [15:0] REMIND_W  = 16'(REMIND_S);

  hood_state_t state_q, state_d;
  logic        pk_q, pk_prev_q;
  logic        ck_q, ck_prev_q;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        hold_ok_q, hold_ok_d;
  logic [15:0] work_sec_q, work_sec_d;
  logic        reminder_q, reminder_d;
  logic        is_on_q, clean_active_q;

  logic        pk_rise, ck_rise, idle;
  logic        g_l, g_r, armed, hold_done, clean_done;
  logic        state_chg, gw_load, gw_zero;
  logic        cd_load, cd_clear, cd_tick;
  logic [7:0]  gw_cnt, cd_cnt;

  assign pk_rise = pk_q & ~pk_prev_q;
  assign ck_rise = ck_q & ~ck_prev_q;
  assign idle    = ~hood_busy & ~hood_cd_active;
  assign g_l     = gesture_l & ~gesture_r;
  assign g_r     = gesture_r & ~gesture_l;
  assign armed   = ~gw_zero;

  assign hold_done = sec_tick & pk_q & hold_ok_q
                   & (hold_cnt_q == HOLD_LAST);
  assign clean_done = (state_q == ST_CLEAN) & sec_tick
                    & (cd_cnt == 8'd1);

  always_comb begin
    state_d = state_q;
    gw_load = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (pk_rise)          state_d = ST_ON;
        else if (g_r && armed) state_d = ST_ON;
        else if (g_l)          gw_load = 1'b1;
      end
      ST_ON: begin
        if (hold_done)                 state_d = ST_OFF;
        else if (ck_rise && idle)      state_d = ST_CLEAN;
        else if (g_l && armed && idle) state_d = ST_OFF;
        else if (g_r)                  gw_load = 1'b1;
      end
      ST_CLEAN: begin
        if (clean_done || hold_done) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  assign state_chg = (state_d != state_q);
  assign cd_load   = (state_q == ST_ON) && (state_d == ST_CLEAN);
  assign cd_clear  = (state_q == ST_CLEAN) && state_chg;
  assign cd_tick   = sec_tick && (state_q == ST_CLEAN);

  // The press that turned the hood on must be released first.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_ok_d  = hold_ok_q;
    if (state_chg) begin
      hold_cnt_d = 8'd0;
      hold_ok_d  = 1'b0;
    end else if (!pk_q) begin
      hold_cnt_d = 8'd0;
      hold_ok_d  = 1'b1;
    end else if (sec_tick && hold_ok_q && state_q != ST_OFF) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_comb begin
    work_sec_d = work_sec_q;
    reminder_d = (work_sec_q >= REMIND_W);
    if (clean_done) begin
      work_sec_d = 16'd0;
      reminder_d = 1'b0;
    end else if (state_q == ST_ON && hood_busy && sec_tick) begin
      work_sec_d = sat_inc16(work_sec_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_OFF;
      pk_q           <= 1'b0;
      pk_prev_q      <= 1'b0;
      ck_q           <= 1'b0;
      ck_prev_q      <= 1'b0;
      hold_cnt_q     <= 8'd0;
      hold_ok_q      <= 1'b0;
      work_sec_q     <= 16'd0;
      reminder_q     <= 1'b0;
      is_on_q        <= 1'b0;
      clean_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pk_q           <= power_key;
      pk_prev_q      <= pk_q;
      ck_q           <= clean_key;
      ck_prev_q      <= ck_q;
      hold_cnt_q     <= hold_cnt_d;
      hold_ok_q      <= hold_ok_d;
      work_sec_q     <= work_sec_d;
      reminder_q     <= reminder_d;
      is_on_q        <= (state_d == ST_ON);
      clean_active_q <= (state_d == ST_CLEAN);
    end
  end

  tick_down_counter u_gesture_win (
    .clk      (clk),
    .rst      (rst),
    .tick     (sec_tick),
    .load     (gw_load),
    .load_val (WIN_LD),
    .clear    (state_chg),
    .count    (gw_cnt),
    .zero     (gw_zero)
  );

  tick_down_counter u_clean_cd (
    .clk      (clk),
    .rst      (rst),
    .tick     (cd_tick),
    .load     (cd_load),
    .load_val (CLEAN_LD),
    .clear    (cd_clear),
    .count    (cd_cnt),
    .zero     ()
  );

  assign is_on        = is_on_q;
  assign clean_active = clean_active_q;
  assign clean_cd     = cd_cnt;
  assign work_sec     = work_sec_q;
  assign reminder     = reminder_q;
  assign state        = state_q;

endmodule

// File: tb/tb_hood_power_ctrl.sv
// Directed bench for hood_power_ctrl with a short reminder
// threshold; expected values are hand-derived.
module tb_hood_power_ctrl;

  logic        clk;
  logic        rst;
  logic        sec_tick;
  logic        power_key;
  logic        clean_key;
  logic        gesture_l;
  logic        gesture_r;
  logic        hood_busy;
  logic        hood_cd_active;
  logic        is_on;
  logic        clean_active;
  logic [7:0]  clean_cd;
  logic [15:0] work_sec;
  logic        reminder;
  logic [1:0]  state;

  int nvec;
  int nerr;

  hood_power_ctrl #(
    .LONG_PRESS_S  (3),
    .GESTURE_WIN_S (5),
    .CLEAN_S       (180),
    .REMIND_S      (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sec_tick       (sec_tick),
    .power_key      (power_key),
    .clean_key      (clean_key),
    .gesture_l      (gesture_l),
    .gesture_r      (gesture_r),
    .hood_busy      (hood_busy),
    .hood_cd_active (hood_cd_active),
    .is_on          (is_on),
    .clean_active   (clean_active),
    .clean_cd       (clean_cd),
    .work_sec       (work_sec),
    .reminder       (reminder),
    .state          (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1;
      step();
      sec_tick = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press_power();
    power_key = 1'b1; step(); step();
    power_key = 1'b0; step(); step();
  endtask

  task automatic enter_clean();
    clean_key = 1'b1; step(); step();
    clean_key = 1'b0; step();
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst = 1'b0; sec_tick = 1'b0; power_key = 1'b0;
    clean_key = 1'b0; gesture_l = 1'b0; gesture_r = 1'b0;
    hood_busy = 1'b0; hood_cd_active = 1'b0;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_is_on", is_on, 0);
    chk("rst_cd", clean_cd, 0);
    chk("rst_work", work_sec, 0);
    rst = 1'b1; step();

    // power key on: is_on on the second edge
    power_key = 1'b1; step();
    chk("pk_cyc1", is_on, 0);
    step();
    chk("pk_cyc2", is_on, 1);
    tick(3);
    chk("pk_held_on", is_on, 1);
    power_key = 1'b0; step(); step();
    power_key = 1'b1; step();
    tick(2);
    chk("lp_tick2", is_on, 1);
    tick(1);
    chk("lp_tick3", is_on, 0);
    chk("lp_state", state, 0);
    power_key = 1'b0; step(); step();

    // gesture on within window, off again
    gesture_l = 1'b1; step(); gesture_l = 1'b0;
    tick(4);
    gesture_r = 1'b1; step(); gesture_r = 1'b0;
    chk("gest_on", state, 1);
    gesture_r = 1'b1; step(); gesture_r = 1'b0;
    gesture_l = 1'b1; step(); gesture_l = 1'b0;
    chk("gest_off", state, 0);
    gesture_l = 1'b1; step(); gesture_l = 1'b0;
    tick(5);
    gesture_r = 1'b1; step(); gesture_r = 1'b0;
    chk("gest_expired", state, 0);
    gesture_l = 1'b1; step();
    gesture_r = 1'b1; step();
    gesture_l = 1'b0; gesture_r = 1'b0;
    chk("gest_both", state, 0);
    gesture_r = 1'b1; step(); gesture_r = 1'b0;
    chk("gest_still_armed", state, 1);
    gesture_r = 1'b1; step(); gesture_r = 1'b0;
    gesture_l = 1'b1; step(); gesture_l = 1'b0;
    chk("gest_off2", state, 0);

    // clean ignored while busy
    press_power();
    chk("on_again", state, 1);
    hood_busy = 1'b1;
    clean_key = 1'b1; step(); step();
    chk("busy_clean_state", state, 1);
    chk("busy_clean_cd", clean_cd, 0);
    clean_key = 1'b0; step(); step();

    // run time and reminder
    tick(4);
    chk("work4", work_sec, 4);
    tick(1);
    chk("work5", work_sec, 5);
    chk("rem_lag", reminder, 0);
    step();
    chk("rem_set", reminder, 1);
    hood_busy = 1'b0;
    power_key = 1'b1; step(); step();
    tick(3);
    chk("off_lp", is_on, 0);
    power_key = 1'b0; step(); step();
    press_power();
    chk("rem_persist", reminder, 1);
    chk("work_persist", work_sec, 5);

    // clean aborted by long press
    enter_clean();
    chk("clean_state", state, 2);
    chk("clean_cd180", clean_cd, 180);
    chk("clean_is_on", is_on, 0);
    chk("clean_active", clean_active, 1);
    power_key = 1'b1; step(); step();
    tick(2);
    chk("abort_cd", clean_cd, 178);
    tick(1);
    chk("abort_state", state, 0);
    chk("abort_cd0", clean_cd, 0);
    chk("abort_work", work_sec, 5);
    power_key = 1'b0; step(); step();

    // async reset mid-clean
    press_power();
    enter_clean();
    tick(80);
    chk("cd100", clean_cd, 100);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_cd", clean_cd, 0);
    chk("arst_work", work_sec, 0);
    chk("arst_rem", reminder, 0);
    chk("arst_active", clean_active, 0);
    step();
    rst = 1'b1; step();

    // full clean cycle
    press_power();
    hood_busy = 1'b1;
    tick(2);
    hood_busy = 1'b0;
    chk("work2", work_sec, 2);
    enter_clean();
    tick(179);
    chk("cd1", clean_cd, 1);
    chk("cd1_state", state, 2);
    tick(1);
    chk("done_state", state, 0);
    chk("done_cd", clean_cd, 0);
    chk("done_work", work_sec, 0);
    chk("done_rem", reminder, 0);
    chk("done_active", clean_active, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
